// File: rtl/mem_pkg.sv
// Shared widths and request record for the bank-memory arbiter.
package mem_pkg;
  localparam int CC_ADDR_W = 13;
  localparam int CC_DATA_W = 64;

  typedef struct packed {
    logic [CC_ADDR_W-1:0] addr;
    logic                 wen;
    logic [CC_DATA_W-1:0] wdata;
  } cc_req_t;
endpackage

// File: rtl/cc_resp_fifo.sv
// Per-requester read-response buffer; head is presented combinationally.
module cc_resp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [CC_DATA_W-1:0]   push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [CC_DATA_W-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][CC_DATA_W-1:0] mem_q;
  logic [PW-1:0]                   wptr_q, rptr_q;
  logic [CW-1:0]                   cnt_q;
  logic                            do_pop;

  assign do_pop  = pop_i & (cnt_q != '0);
  assign valid_o = (cnt_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PW'(1);
      if (do_pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end
endmodule

// File: rtl/cc_banks_arb.sv
// Two-requester round-robin arbiter in front of a single-port 8K x 64 bank,
// with credit-gated reads returning through per-requester response FIFOs.
module cc_banks_arb
  import mem_pkg::*;
#(
  parameter int RESP_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [1:0][CC_ADDR_W-1:0] req_addr,
  input  logic [1:0]                req_wen,
  input  logic [1:0][CC_DATA_W-1:0] req_wdata,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [1:0][CC_DATA_W-1:0] resp_rdata,
  output logic [CC_ADDR_W-1:0]      RW0_addr,
  output logic                      RW0_en,
  output logic                      RW0_wmode,
  output logic [CC_DATA_W-1:0]      RW0_wdata,
  input  logic [CC_DATA_W-1:0]      RW0_rdata
);
  localparam int NUM_REQ = 2;
  localparam int CW      = $clog2(RESP_DEPTH) + 1;

  cc_req_t [NUM_REQ-1:0]          req;
  cc_req_t                        sel;
  logic [NUM_REQ-1:0][CW-1:0]     cnt;
  logic [NUM_REQ-1:0]             elig, push;
  logic                           en_q;
  logic                           last_grant_q, last_grant_d;
  logic                           inflight_q, inflight_d;
  logic                           owner_q, owner_d;
  logic                           gnt_any, gnt_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign req[i].addr  = req_addr[i];
    assign req[i].wen   = req_wen[i];
    assign req[i].wdata = req_wdata[i];
    // The read in flight lands in this FIFO next edge, so it already holds a credit.
    assign push[i] = inflight_q & (owner_q == 1'(i));
    assign elig[i] = en_q & req_valid[i] &
                     (req_wen[i] | ((cnt[i] + CW'(push[i])) < CW'(RESP_DEPTH)));

    cc_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[i]),
      .push_data_i (RW0_rdata),
      .pop_i       (resp_valid[i] & resp_ready[i]),
      .valid_o     (resp_valid[i]),
      .rdata_o     (resp_rdata[i]),
      .count_o     (cnt[i])
    );
  end

  always_comb begin
    gnt_any      = |elig;
    gnt_idx      = 1'b0;
    req_ready    = '0;
    if (&elig) gnt_idx = ~last_grant_q;
    else       gnt_idx = elig[1];
    if (gnt_any) req_ready[gnt_idx] = 1'b1;
    sel          = req[gnt_idx];
    RW0_en       = gnt_any;
    RW0_wmode    = gnt_any & sel.wen;
    RW0_addr     = sel.addr;
    RW0_wdata    = sel.wdata;
    last_grant_d = gnt_any ? gnt_idx : last_grant_q;
    inflight_d   = gnt_any & ~sel.wen;
    owner_d      = gnt_any ? gnt_idx : owner_q;
  end

  // en_q holds off grants until the first edge after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      last_grant_q <= 1'b1;
      inflight_q   <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      owner_q      <= owner_d;
    end
  end
endmodule
